// File: rtl/lag_measure.sv
// rtl/lag_measure.sv - multi-channel debounced input-lag timer with min/max/average statistics
// Each channel times start-to-sensor lag in tick units and keeps running statistics.
module lag_measure #(
  parameter int CHANNELS  = 2,
  parameter int CNT_WIDTH = 20,
  parameter int DEBOUNCE  = 16,
  parameter int AVG_SHIFT = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          start,
  input  logic                          clear,
  input  logic [CHANNELS-1:0]           sensor,
  output logic [CHANNELS-1:0]           armed,
  output logic [CHANNELS-1:0]           lag_valid,
  output logic [CHANNELS-1:0]           lag_timeout,
  output logic [CHANNELS*CNT_WIDTH-1:0] lag_out,
  output logic [CHANNELS*CNT_WIDTH-1:0] min_out,
  output logic [CHANNELS*CNT_WIDTH-1:0] max_out,
  output logic [CHANNELS*CNT_WIDTH-1:0] avg_out,
  output logic [CHANNELS-1:0]           avg_valid
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam int SUM_W = CNT_WIDTH + AVG_SHIFT;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic                 s_meta, s_sync;
      state_t               state, state_nx;
      logic [CNT_WIDTH-1:0] count, count_nx;
      logic [CNT_WIDTH-1:0] cand, cand_nx;
      logic                 cand_ok, cand_ok_nx;
      logic [DEB_W-1:0]     deb, deb_nx;
      logic                 hit, to_hit;
      logic [CNT_WIDTH-1:0] commit_val;

      logic                 valid_q, timeout_q;
      logic [CNT_WIDTH-1:0] lag_q;
      logic [CNT_WIDTH-1:0] min_q, max_q, avg_q;
      logic [SUM_W-1:0]     sum_q, sum_nx;
      logic [AVG_SHIFT-1:0] n_q;
      logic                 avg_valid_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          s_meta <= 1'b0;
          s_sync <= 1'b0;
        end else begin
          s_meta <= sensor[c];
          s_sync <= s_meta;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          state   <= ST_IDLE;
          count   <= '0;
          cand    <= '0;
          cand_ok <= 1'b0;
          deb     <= '0;
        end else begin
          state   <= state_nx;
          count   <= count_nx;
          cand    <= cand_nx;
          cand_ok <= cand_ok_nx;
          deb     <= deb_nx;
        end
      end

      // With DEBOUNCE=1 the commit happens in the same cycle the candidate would be latched.
      assign commit_val = cand_ok ? cand : count;

      always_comb begin
        state_nx   = state;
        count_nx   = count;
        cand_nx    = cand;
        cand_ok_nx = cand_ok;
        deb_nx     = deb;
        hit        = 1'b0;
        to_hit     = 1'b0;
        case (state)
          ST_ARMED: begin
            if (s_sync) begin
              deb_nx = deb + 1'b1;
              if (!cand_ok) begin
                cand_nx    = count;
                cand_ok_nx = 1'b1;
              end
            end else begin
              deb_nx     = '0;
              cand_ok_nx = 1'b0;
            end
            if (s_sync && deb == DEB_LAST) begin
              hit = 1'b1;
            end else if (tick && count == {CNT_WIDTH{1'b1}}) begin
              to_hit = 1'b1;
            end else if (tick) begin
              count_nx = count + 1'b1;
            end
            if (hit || to_hit) begin
              state_nx = ST_IDLE;
            end
          end
          default: begin
            state_nx = ST_IDLE;
          end
        endcase
        // A start always wins over the FSM, even in a commit cycle.
        if (start) begin
          state_nx   = ST_ARMED;
          count_nx   = '0;
          deb_nx     = '0;
          cand_ok_nx = 1'b0;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          valid_q   <= 1'b0;
          timeout_q <= 1'b0;
          lag_q     <= '0;
        end else begin
          valid_q   <= hit | to_hit;
          timeout_q <= to_hit;
          if (hit) begin
            lag_q <= commit_val;
          end else if (to_hit) begin
            lag_q <= '1;
          end
        end
      end

      assign sum_nx = sum_q + SUM_W'(commit_val);

      always_ff @(posedge clock) begin
        if (reset || clear) begin
          min_q       <= '1;
          max_q       <= '0;
          sum_q       <= '0;
          n_q         <= '0;
          avg_q       <= '0;
          avg_valid_q <= 1'b0;
        end else begin
          avg_valid_q <= 1'b0;
          if (hit) begin
            if (commit_val < min_q) begin
              min_q <= commit_val;
            end
            if (commit_val > max_q) begin
              max_q <= commit_val;
            end
            if (n_q == {AVG_SHIFT{1'b1}}) begin
              avg_q       <= sum_nx[SUM_W-1:AVG_SHIFT];
              sum_q       <= '0;
              avg_valid_q <= 1'b1;
            end else begin
              sum_q <= sum_nx;
            end
            n_q <= n_q + 1'b1;
          end
        end
      end

      assign armed[c]                              = (state == ST_ARMED);
      assign lag_valid[c]                          = valid_q;
      assign lag_timeout[c]                        = timeout_q;
      assign avg_valid[c]                          = avg_valid_q;
      assign lag_out[c*CNT_WIDTH +: CNT_WIDTH]     = lag_q;
      assign min_out[c*CNT_WIDTH +: CNT_WIDTH]     = min_q;
      assign max_out[c*CNT_WIDTH +: CNT_WIDTH]     = max_q;
      assign avg_out[c*CNT_WIDTH +: CNT_WIDTH]     = avg_q;
    end
  endgenerate

endmodule

// File: tb/tb_lag_measure.sv
// tb/tb_lag_measure.sv - self-checking bench for lag_measure
// A default-width instance runs against a reference model; an 8-bit instance covers saturation.
module tb_lag_measure;
  localparam int CH = 2;
  localparam int W  = 20;
  localparam int DEB = 16;
  localparam int AS = 4;
  localparam int W8 = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick  = 1'b0;
  logic start = 1'b0;
  logic clear = 1'b0;
  logic [CH-1:0]   sensor = '0;
  logic [CH-1:0]   armed, lag_valid, lag_timeout, avg_valid;
  logic [CH*W-1:0] lag_out, min_out, max_out, avg_out;

  logic start8 = 1'b0;
  logic tick8  = 1'b1;
  logic [0:0]    sensor8 = '0;
  logic [0:0]    armed8, lag_valid8, lag_timeout8, avg_valid8;
  logic [W8-1:0] lag_out8, min_out8, max_out8, avg_out8;

  lag_measure #(.CHANNELS(CH), .CNT_WIDTH(W), .DEBOUNCE(DEB), .AVG_SHIFT(AS)) dut (
    .clock(clock), .reset(reset), .tick(tick), .start(start), .clear(clear),
    .sensor(sensor), .armed(armed), .lag_valid(lag_valid), .lag_timeout(lag_timeout),
    .lag_out(lag_out), .min_out(min_out), .max_out(max_out), .avg_out(avg_out),
    .avg_valid(avg_valid)
  );

  lag_measure #(.CHANNELS(1), .CNT_WIDTH(W8), .DEBOUNCE(DEB), .AVG_SHIFT(AS)) dut8 (
    .clock(clock), .reset(reset), .tick(tick8), .start(start8), .clear(clear),
    .sensor(sensor8), .armed(armed8), .lag_valid(lag_valid8), .lag_timeout(lag_timeout8),
    .lag_out(lag_out8), .min_out(min_out8), .max_out(max_out8), .avg_out(avg_out8),
    .avg_valid(avg_valid8)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int phase = 0;
  bit rand_tick = 0;
  logic last_tick;
  logic [CH-1:0] seen_valid = '0;

  // Reference model: lag = ticks seen strictly between the start edge and the
  // first edge of the qualifying sensor run; stats kept as a window of results.
  logic [CH-1:0]   e_armed, e_valid, e_to, e_avgv;
  logic [CH*W-1:0] e_lag, e_min, e_max, e_avg;
  logic [CH-1:0]   hist1, hist2, s_now;
  bit m_armed[CH];
  int m_ticks[CH], m_run[CH], m_cand[CH];
  int win[CH][16];
  int win_n[CH];
  bit got;
  int msum;

  always @(posedge clock) begin
    if (reset) begin
      e_armed = '0; e_valid = '0; e_to = '0; e_avgv = '0;
      e_lag = '0; e_min = '1; e_max = '0; e_avg = '0;
      hist1 = '0; hist2 = '0;
      for (int c = 0; c < CH; c++) begin
        m_armed[c] = 0;
        win_n[c] = 0;
      end
    end else begin
      s_now = hist2; hist2 = hist1; hist1 = sensor;
      e_valid = '0; e_to = '0; e_avgv = '0;
      for (int c = 0; c < CH; c++) begin
        got = 0;
        if (m_armed[c]) begin
          if (s_now[c]) begin
            m_run[c]++;
            if (m_run[c] == 1) m_cand[c] = m_ticks[c];
          end else begin
            m_run[c] = 0;
          end
          if (m_run[c] == DEB) begin
            e_valid[c] = 1'b1;
            e_lag[c*W +: W] = m_cand[c][W-1:0];
            m_armed[c] = 0;
            got = 1;
          end else if (tick) begin
            m_ticks[c]++;
            if (m_ticks[c] == (1 << W)) begin
              e_valid[c] = 1'b1;
              e_to[c] = 1'b1;
              e_lag[c*W +: W] = '1;
              m_armed[c] = 0;
            end
          end
        end
        if (start) begin
          m_armed[c] = 1;
          m_ticks[c] = 0;
          m_run[c] = 0;
        end
        if (clear) begin
          e_min[c*W +: W] = '1;
          e_max[c*W +: W] = '0;
          e_avg[c*W +: W] = '0;
          win_n[c] = 0;
        end else if (got) begin
          if (m_cand[c] < int'(e_min[c*W +: W])) e_min[c*W +: W] = m_cand[c][W-1:0];
          if (m_cand[c] > int'(e_max[c*W +: W])) e_max[c*W +: W] = m_cand[c][W-1:0];
          win[c][win_n[c]] = m_cand[c];
          win_n[c]++;
          if (win_n[c] == (1 << AS)) begin
            msum = 0;
            for (int i = 0; i < (1 << AS); i++) msum += win[c][i];
            msum = msum >> AS;
            e_avg[c*W +: W] = msum[W-1:0];
            e_avgv[c] = 1'b1;
            win_n[c] = 0;
          end
        end
        e_armed[c] = m_armed[c];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    last_tick = tick;
    @(posedge clock);
    #1;
    if (last_tick && !reset) tick_cnt++;
    seen_valid |= lag_valid;
    chk("armed", armed, e_armed);
    chk("lag_valid", lag_valid, e_valid);
    chk("lag_timeout", lag_timeout, e_to);
    chk("lag_out", lag_out, e_lag);
    chk("min_out", min_out, e_min);
    chk("max_out", max_out, e_max);
    chk("avg_out", avg_out, e_avg);
    chk("avg_valid", avg_valid, e_avgv);
    if (rand_tick) begin
      tick = ($urandom_range(0, 2) == 0);
    end else begin
      phase = (phase + 1) % 4;
      tick = (phase == 0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    tick_cnt = 0;
    seen_valid = '0;
  endtask

  task automatic wait_ticks(input int n);
    int guard;
    guard = 0;
    while (tick_cnt < n && guard < 5000) begin
      cyc();
      guard++;
    end
    chk("wait_ticks", tick_cnt >= n, 1);
  endtask

  task automatic wait_valid(input logic [CH-1:0] mask, input string tag, input int budget);
    int k;
    k = 0;
    while ((seen_valid & mask) != mask && k < budget) begin
      cyc();
      k++;
    end
    chk(tag, (seen_valid & mask) == mask, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_armed"}, armed, 0);
    chk({tag, "_valid"}, lag_valid, 0);
    chk({tag, "_timeout"}, lag_timeout, 0);
    chk({tag, "_lag"}, lag_out, 0);
    chk({tag, "_min"}, min_out, {CH*W{1'b1}});
    chk({tag, "_max"}, max_out, 0);
    chk({tag, "_avg"}, avg_out, 0);
    chk({tag, "_avgv"}, avg_valid, 0);
  endtask

  initial begin
    logic [CH-1:0] mask;
    int lag, k;

    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk_reset_vals("reset");

    // Basic lag of 100 ticks on channel 0.
    pulse_start();
    chk("arm_rise", armed, 2'b11);
    wait_ticks(100);
    sensor[0] = 1'b1;
    wait_valid(2'b01, "t1_wait", 200);
    chk("t1_lag", lag_out[W-1:0], 100);
    chk("t1_timeout", lag_timeout[0], 0);
    chk("t1_min", min_out[W-1:0], 100);
    chk("t1_max", max_out[W-1:0], 100);
    sensor[0] = 1'b0;
    cyc();
    chk("t1_armed_fall", armed[0], 0);
    repeat (4) cyc();

    // Glitch on channel 1 is discarded.
    pulse_start();
    wait_ticks(50);
    sensor[1] = 1'b1;
    repeat (10) cyc();
    sensor[1] = 1'b0;
    wait_ticks(80);
    sensor[1] = 1'b1;
    wait_valid(2'b10, "t2_wait", 200);
    chk("t2_lag", lag_out[W +: W], 80);
    chk("t2_min", min_out[W +: W], 80);
    sensor[1] = 1'b0;
    repeat (4) cyc();

    // Saturation on the 8-bit instance.
    start8 = 1'b1;
    cyc();
    start8 = 1'b0;
    k = 0;
    while (!lag_valid8[0] && k < 400) begin
      cyc();
      k++;
    end
    chk("t3_valid", lag_valid8, 1);
    chk("t3_timeout", lag_timeout8, 1);
    chk("t3_lag", lag_out8, 8'hFF);
    chk("t3_min", min_out8, 8'hFF);
    chk("t3_max", max_out8, 0);
    chk("t3_avgv", avg_valid8, 0);
    cyc();
    chk("t3_armed", armed8, 0);

    // Sixteen lags 10..25 fill the average window.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    for (int l = 10; l <= 25; l++) begin
      pulse_start();
      wait_ticks(l);
      sensor[0] = 1'b1;
      wait_valid(2'b01, "t4_wait", 200);
      if (l < 25) chk("t4_avgv_early", avg_valid[0], 0);
      sensor[0] = 1'b0;
      if (l < 25) repeat (4) cyc();
    end
    chk("t4_avgv", avg_valid[0], 1);
    chk("t4_avg", avg_out[W-1:0], 17);
    chk("t4_min", min_out[W-1:0], 10);
    chk("t4_max", max_out[W-1:0], 25);
    repeat (4) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("t4_clr_min", min_out, {CH*W{1'b1}});
    chk("t4_clr_max", max_out, 0);
    chk("t4_clr_avg", avg_out, 0);

    // Restart while armed, then start colliding with a commit.
    pulse_start();
    wait_ticks(40);
    pulse_start();
    wait_ticks(30);
    sensor[0] = 1'b1;
    wait_valid(2'b01, "t5_wait", 200);
    chk("t5_lag", lag_out[W-1:0], 30);
    sensor[0] = 1'b0;
    repeat (4) cyc();
    pulse_start();
    wait_ticks(5);
    sensor[0] = 1'b1;
    repeat (DEB + 1) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t5_coll_valid", lag_valid[0], 1);
    chk("t5_coll_armed", armed[0], 1);
    chk("t5_coll_lag", lag_out[W-1:0], 5);
    sensor[0] = 1'b0;
    repeat (4) cyc();

    // Reset in the middle of a measurement.
    pulse_start();
    wait_ticks(60);
    reset = 1'b1;
    cyc();
    chk_reset_vals("midrst");
    reset = 1'b0;
    repeat (3) cyc();
    chk("midrst_quiet", lag_valid, 0);

    // Randomized measurements with glitches, random ticks and stray clears.
    rand_tick = 1;
    repeat (24) begin
      mask = 2'($urandom_range(1, 3));
      pulse_start();
      lag = $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 1) begin
        wait_ticks(lag / 2);
        sensor = mask;
        repeat ($urandom_range(1, DEB - 2)) cyc();
        sensor = '0;
      end
      wait_ticks(lag);
      sensor = mask;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, DEB + 4)) cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
      end
      wait_valid(mask, "rand_wait", 400);
      sensor = '0;
      repeat (4) cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
